peri_uart_fifo: RTL
===================

Name: peri_uart_fifo

Overview:
- Memory-mapped UART register block with parametrised TX and RX FIFOs, a status register, interrupt enables and sticky overrun flags.
- Sits on the peripheral read/write bus between the core and the uart serializer core.
- Returns read data one cycle after rden, so timing matches RAM.
- Drives the uart core through its tx_data_valid/tx_data_ack and rx_data_fresh interface.

Parameters:
- BASE_ADDR, 32'h20000, byte address of DR. SR is at +4. IER is at +8.
- TX_DEPTH, 8, TX FIFO entries. Must be a power of two, ≥2.
- RX_DEPTH, 8, RX FIFO entries. Must be a power of two, ≥2.

Ports:
- clk  in  1  system clock; the uart core runs on the same clock.
- rst  in  1  asynchronous, active-high reset.
- rdaddress  in  32  read byte address.
- rden  in  1  read strobe.
- rdata  out  32  read data, valid the cycle after rden.
- wraddress  in  32  write byte address.
- wdata  in  32  write data.
- wrbyteena  in  4  byte enables; only bit 0 is used.
- wren  in  1  write strobe.
- tx_data  out  8  byte presented to the uart core.
- tx_data_valid  out  1  tx_data is valid; held until ack.
- tx_data_ack  in  1  one-cycle pulse: byte transmitted.
- rx_data  in  8  received byte.
- rx_data_fresh  in  1  one-cycle pulse: rx_data valid.
- uart_intr  out  1  level interrupt, registered.

Behaviour:
- Single clock. Reset is asynchronous and active-high.
- Reset values:
  - FIFOs empty; TX FSM in IDLE.
  - tx_data_valid=0, tx_data=0.
  - rdata=0, uart_intr=0.
  - IER=0; overrun flags=0.
- Address decode:
  - Reads decode rdaddress against the full 32-bit address, gated by rden.
  - Writes decode wraddress, gated by wren & wrbyteena[0].
  - Unmapped read returns 0. Unmapped write is ignored.
- DR write: push wdata[7:0] into the TX FIFO.
  - If the FIFO is full, drop the byte and set TXOVR.
- DR read: pop the RX head. rdata={24'h0, head} in the next cycle.
  - If the FIFO is empty, rdata=0, no pop, no error.
- RX push: on rx_data_fresh, push rx_data.
  - If the FIFO is full and no same-cycle DR read, drop the byte and set RXOVR.
  - If the FIFO is full and a DR read occurs in the same cycle, push and pop both succeed and the count is unchanged.
- TX FIFO: a simultaneous push and pop when full behaves the same way (both succeed).
- SR read value:
  - [0] rx_not_empty
  - [1] rx_full
  - [2] tx_empty
  - [3] tx_full
  - [4] RXOVR
  - [5] TXOVR
  - [6] tx_busy (FSM in SEND)
  - [15:8] rx_count, zero-extended
  - [23:16] tx_count, zero-extended
  - others 0
- SR write: write-1-to-clear on bits 4 and 5; other bits are ignored.
  - A set event in the same cycle as a clear wins (the flag stays set).
- IER: read/write register, bits [2:0], other bits read 0.
  - [0] RX not-empty enable
  - [1] TX empty enable
  - [2] overrun enable
- TX FSM:
  - IDLE: if the TX FIFO is not empty, latch the head into tx_data, assert tx_data_valid, pop, go to SEND.
  - SEND: hold tx_data and tx_data_valid until tx_data_ack. On ack, deassert tx_data_valid and go to IDLE.
  - A minimum of one idle cycle separates bytes.
  - tx_data_ack seen in IDLE is ignored.
- uart_intr = registered OR of:
  - (IER[0] & rx_not_empty)
  - (IER[1] & tx_empty & ~tx_busy)
  - (IER[2] & (RXOVR|TXOVR))
- Interrupt timing: uart_intr updates one cycle after any cause changes. Reading DR until the RX FIFO is empty deasserts it.
- Read latency is always exactly 1 cycle. A DR read pops in the same cycle rden is sampled.
- Wrap-around: pointers are log2(DEPTH)+1 bits wide. Full = MSBs differ and the other bits are equal. Pointers wrap silently.
- Asserting rst mid-SEND:
  - drops tx_data_valid immediately and flushes both FIFOs;
  - the byte in flight is lost;
  - a later stray ack is ignored.

Decomposition:
- Package peri_uart_pkg holds:
  - register offsets DR_OFS=0, SR_OFS=4, IER_OFS=8;
  - SR and IER bit-index constants;
  - TX FSM state encoding (IDLE, SEND).
- Sub-module sync_fifo (WIDTH, DEPTH), instantiated twice for TX and RX.
  - Ports: push, pop, din, dout (head, combinational), full, empty, count.

Test Plan:
- Reset, then read SR → rdata=32'h0000_0004 the next cycle (tx_empty only); uart_intr=0.
- Write DR 0x41, 0x42, 0x43; pulse ack 5 cycles after each valid → tx_data sequence 41, 42, 43, each held until its ack; SR[2]=1 afterwards.
- With TX_DEPTH=8 and ack withheld, write DR 10 times → first byte in SEND, 8 bytes queued, 10th dropped; SR reads tx_full=1, TXOVR=1, tx_count=8; writing SR 0x20 clears TXOVR.
- With IER=1, pulse rx_data_fresh with 0x5A → uart_intr=1 two cycles later; DR read returns 0x5A, then uart_intr=0; a further DR read returns 0.
- Fill RX with 8 bytes, then rx_data_fresh and a DR read in the same cycle → no RXOVR, rx_count stays 8, FIFO order preserved.
- Assert rst while tx_data_valid=1 → tx_data_valid=0 and both FIFOs empty immediately (asynchronous); a later ack has no effect.

Source files
------------

// File: rtl/peri_uart_pkg.sv
// rtl/peri_uart_pkg.sv - register map, status/enable bit indices and TX FSM states for the UART block
package peri_uart_pkg;

    localparam logic [31:0] DR_OFS  = 32'h0;
    localparam logic [31:0] SR_OFS  = 32'h4;
    localparam logic [31:0] IER_OFS = 32'h8;

    localparam int SR_RX_NOT_EMPTY = 0;
    localparam int SR_RX_FULL      = 1;
    localparam int SR_TX_EMPTY     = 2;
    localparam int SR_TX_FULL      = 3;
    localparam int SR_RXOVR        = 4;
    localparam int SR_TXOVR        = 5;
    localparam int SR_TX_BUSY      = 6;

    localparam int IER_RX_NE  = 0;
    localparam int IER_TX_EMP = 1;
    localparam int IER_OVR    = 2;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/peri_uart_fifo_sync_fifo.sv
// rtl/peri_uart_fifo_sync_fifo.sv - single-clock FIFO with combinational head and extra-MSB pointers
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count = r_wr_ptr - r_rd_ptr;
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/peri_uart_fifo.sv
// rtl/peri_uart_fifo.sv - memory-mapped UART register block with TX/RX FIFOs, status, IER and overrun flags
module peri_uart_fifo
    import peri_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h20000,
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rdaddress,
    input  logic        rden,
    output logic [31:0] rdata,
    input  logic [31:0] wraddress,
    input  logic [31:0] wdata,
    input  logic [3:0]  wrbyteena,
    input  logic        wren,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ack,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_fresh,
    output logic        uart_intr
);
    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;

    logic            w_rd_dr, w_rd_sr, w_rd_ier;
    logic            w_wr_en, w_wr_dr, w_wr_sr, w_wr_ier;
    logic [7:0]      w_tx_dout, w_rx_dout;
    logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [TXCW-1:0] w_tx_count;
    logic [RXCW-1:0] w_rx_count;
    logic            w_tx_pop, w_tx_busy;
    logic            w_rxovr_set, w_txovr_set;
    logic [31:0]     w_sr;
    logic            w_unused;
    tx_state_t       r_state, w_state_next;
    logic [7:0]      r_tx_data;
    logic [31:0]     r_rdata;
    logic [2:0]      r_ier;
    logic            r_rxovr, r_txovr, r_intr;

    assign w_unused = ^{wdata[31:8], wrbyteena[3:1]};

    assign w_rd_dr  = rden && (rdaddress == BASE_ADDR + DR_OFS);
    assign w_rd_sr  = rden && (rdaddress == BASE_ADDR + SR_OFS);
    assign w_rd_ier = rden && (rdaddress == BASE_ADDR + IER_OFS);
    assign w_wr_en  = wren & wrbyteena[0];
    assign w_wr_dr  = w_wr_en && (wraddress == BASE_ADDR + DR_OFS);
    assign w_wr_sr  = w_wr_en && (wraddress == BASE_ADDR + SR_OFS);
    assign w_wr_ier = w_wr_en && (wraddress == BASE_ADDR + IER_OFS);

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(w_wr_dr), .pop(w_tx_pop), .din(wdata[7:0]),
        .dout(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_data_fresh), .pop(w_rd_dr), .din(rx_data),
        .dout(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    // Overruns only when the full FIFO is not draining in the same cycle.
    assign w_rxovr_set = rx_data_fresh & w_rx_full & ~w_rd_dr;
    assign w_txovr_set = w_wr_dr & w_tx_full & ~w_tx_pop;

    always_comb begin
        w_state_next = r_state;
        w_tx_pop     = 1'b0;
        case (r_state)
            TX_IDLE: if (!w_tx_empty) begin
                w_tx_pop     = 1'b1;
                w_state_next = TX_SEND;
            end
            TX_SEND: if (tx_data_ack) w_state_next = TX_IDLE;
            default: w_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= TX_IDLE;
            r_tx_data <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_tx_pop) r_tx_data <= w_tx_dout;
        end
    end

    assign w_tx_busy     = (r_state == TX_SEND);
    assign tx_data_valid = w_tx_busy;
    assign tx_data       = r_tx_data;

    always_comb begin
        w_sr                  = '0;
        w_sr[SR_RX_NOT_EMPTY] = ~w_rx_empty;
        w_sr[SR_RX_FULL]      = w_rx_full;
        w_sr[SR_TX_EMPTY]     = w_tx_empty;
        w_sr[SR_TX_FULL]      = w_tx_full;
        w_sr[SR_RXOVR]        = r_rxovr;
        w_sr[SR_TXOVR]        = r_txovr;
        w_sr[SR_TX_BUSY]      = w_tx_busy;
        w_sr[15:8]            = 8'(w_rx_count);
        w_sr[23:16]           = 8'(w_tx_count);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
            r_ier   <= '0;
            r_rxovr <= 1'b0;
            r_txovr <= 1'b0;
            r_intr  <= 1'b0;
        end else begin
            if (w_rd_dr)       r_rdata <= w_rx_empty ? 32'h0 : {24'h0, w_rx_dout};
            else if (w_rd_sr)  r_rdata <= w_sr;
            else if (w_rd_ier) r_rdata <= {29'h0, r_ier};
            else               r_rdata <= '0;
            if (w_wr_ier) r_ier <= wdata[2:0];
            r_rxovr <= w_rxovr_set | (r_rxovr & ~(w_wr_sr & wdata[SR_RXOVR]));
            r_txovr <= w_txovr_set | (r_txovr & ~(w_wr_sr & wdata[SR_TXOVR]));
            r_intr  <= (r_ier[IER_RX_NE] & ~w_rx_empty)
                     | (r_ier[IER_TX_EMP] & w_tx_empty & ~w_tx_busy)
                     | (r_ier[IER_OVR] & (r_rxovr | r_txovr));
        end
    end

    assign rdata     = r_rdata;
    assign uart_intr = r_intr;

endmodule
